// File: rtl/utopia_rx_phy.sv
// UTOPIA L1 Rx PHY cell buffer: byte-wide load side, cell-framed Rx side.
// Optional HEC insertion at cell offset 4 when UTOPIA_RX_PHY_HEC_EN is defined.
module utopia_rx_phy #(
  parameter int CELL_BYTES = 53,
  parameter int NCELLS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ld_data,
  input  logic       ld_soc,
  input  logic       ld_valid,
  output logic       ld_ready,
  output logic [7:0] Rx_data,
  output logic       Rx_soc,
  input  logic       Rx_en,
  output logic       Rx_clav,
  output logic       err
);

  localparam int TOTAL = NCELLS * CELL_BYTES;
  localparam int AW    = $clog2(TOTAL);
  localparam int OW    = $clog2(CELL_BYTES);
  localparam int CW    = $clog2(NCELLS + 1);
  localparam int SW    = $clog2(TOTAL + 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(TOTAL - CELL_BYTES);
  localparam logic [OW-1:0] LAST_OFF  = OW'(CELL_BYTES - 1);

  typedef enum logic {IDLE, FILL}   wstate_t;
  typedef enum logic {RIDLE, RSEND} rstate_t;

  logic [7:0] mem [TOTAL];

  wstate_t       wstate, wstate_n;
  rstate_t       rstate, rstate_n;
  logic [OW-1:0] wr_off, wr_off_n, rd_off, rd_off_n, woff;
  logic [AW-1:0] wcell, wcell_n, rcell, rcell_n, waddr;
  logic [CW-1:0] count, count_n;
  logic [SW-1:0] used;
  logic [7:0]    wdata;
  logic          accept, we, done, dec, err_n, avail;

  // Occupancy counts complete cells (including the one being read) plus the partial cell.
  assign used     = SW'(count) * SW'(CELL_BYTES) + SW'(wr_off);
  assign ld_ready = (used < SW'(TOTAL));
  assign accept   = ld_valid && ld_ready;

`ifdef UTOPIA_RX_PHY_HEC_EN
  logic [7:0] crc, crc_n;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_n = crc;
    if (we && woff == '0) begin
      crc_n = crc8_step(8'h00, ld_data);
    end else if (we && woff < OW'(4)) begin
      crc_n = crc8_step(crc, ld_data);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc <= '0;
    else      crc <= crc_n;
  end

  assign wdata = (woff == OW'(4)) ? (crc ^ 8'h55) : ld_data;
`else
  assign wdata = ld_data;
`endif

  // Load FSM: a start-of-cell byte always restarts the current slot at offset 0.
  always_comb begin
    wstate_n = wstate;
    wr_off_n = wr_off;
    wcell_n  = wcell;
    woff     = wr_off;
    we       = 1'b0;
    done     = 1'b0;
    err_n    = 1'b0;
    if (accept) begin
      if (ld_soc) begin
        err_n    = (wstate == FILL);
        woff     = '0;
        we       = 1'b1;
        wr_off_n = OW'(1);
        wstate_n = FILL;
      end else if (wstate == IDLE) begin
        err_n = 1'b1;
      end else begin
        we = 1'b1;
        if (wr_off == LAST_OFF) begin
          done     = 1'b1;
          wr_off_n = '0;
          wcell_n  = (wcell == LAST_CELL) ? '0 : wcell + AW'(CELL_BYTES);
          wstate_n = IDLE;
        end else begin
          wr_off_n = wr_off + OW'(1);
        end
      end
    end
  end

  assign waddr = wcell + AW'(woff);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read FSM: RIDLE presents byte 0 of the head cell whenever one is complete.
  assign avail   = (rstate == RSEND) || (count != '0);
  assign Rx_data = avail ? mem[rcell + AW'(rd_off)] : '0;
  assign Rx_soc  = (rstate == RIDLE) && (count != '0);

  always_comb begin
    rstate_n = rstate;
    rd_off_n = rd_off;
    rcell_n  = rcell;
    dec      = 1'b0;
    if (!Rx_en && avail) begin
      if (rstate == RIDLE) begin
        rd_off_n = OW'(1);
        rstate_n = RSEND;
      end else if (rd_off == LAST_OFF) begin
        dec      = 1'b1;
        rd_off_n = '0;
        rcell_n  = (rcell == LAST_CELL) ? '0 : rcell + AW'(CELL_BYTES);
        rstate_n = RIDLE;
      end else begin
        rd_off_n = rd_off + OW'(1);
      end
    end
  end

  assign count_n = count + CW'(done) - CW'(dec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate  <= IDLE;
      wr_off  <= '0;
      wcell   <= '0;
      rstate  <= RIDLE;
      rd_off  <= '0;
      rcell   <= '0;
      count   <= '0;
      Rx_clav <= 1'b0;
      err     <= 1'b0;
    end else begin
      wstate  <= wstate_n;
      wr_off  <= wr_off_n;
      wcell   <= wcell_n;
      rstate  <= rstate_n;
      rd_off  <= rd_off_n;
      rcell   <= rcell_n;
      count   <= count_n;
      Rx_clav <= (count_n != '0);
      err     <= err_n;
    end
  end

endmodule

// File: doc/utopia_rx_phy.md
UTOPIA_RX_PHY -- requirements
Module: utopia_rx_phy

Interface
REQ-001 Parameter CELL_BYTES, default 53, bytes per ATM cell.
REQ-002 Parameter NCELLS, default 2, cell slots in the internal buffer.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ld_data  input  8  cell byte from the cell source.
REQ-006 ld_soc  input  1  high with byte 0 of a cell.
REQ-007 ld_valid  input  1  ld_data/ld_soc valid this cycle.
REQ-008 ld_ready  output  1  buffer can accept a byte this cycle.
REQ-009 Rx_data  output  8  Utopia L1 Rx cell byte, driven toward the switch Rx port.
REQ-010 Rx_soc  output  1  high while Rx_data is byte 0 of a cell.
REQ-011 Rx_en  input  1  Utopia read enable, active-low, driven by the switch.
REQ-012 Rx_clav  output  1  at least one complete cell is available.
REQ-013 err  output  1  one-cycle pulse on a framing error at the load side.

Function
REQ-014 Buffer SHALL hold NCELLS*CELL_BYTES bytes, written and read in cell order, with independent byte write/read pointers that wrap at NCELLS*CELL_BYTES.
REQ-015 A load byte SHALL be accepted on a rising edge with ld_valid=1 and ld_ready=1.
REQ-016 ld_ready SHALL be high iff at least one byte location is free; free space SHALL include the slot being read only after its last byte is consumed.
REQ-017 Write state machine SHALL have states IDLE (expect byte 0) and FILL (bytes 1..CELL_BYTES-1).
REQ-018 In IDLE, a byte with ld_soc=0 SHALL be dropped, the state SHALL stay IDLE, and err SHALL pulse.
REQ-019 In IDLE, a byte with ld_soc=1 SHALL be written and the state SHALL go to FILL.
REQ-020 In FILL, a byte with ld_soc=1 SHALL pulse err, rewind the write pointer to the current cell start, write the byte as byte 0, and stay in FILL.
REQ-021 When byte CELL_BYTES-1 is written, the complete-cell count SHALL increment and the state SHALL return to IDLE.
REQ-022 Rx_clav SHALL be high iff the complete-cell count is at least 1 and is registered.
REQ-023 Rx_clav SHALL rise on the edge following completion of a cell.
REQ-024 Read state machine SHALL have states RIDLE and RSEND.
REQ-025 In RIDLE with count at least 1, Rx_data SHALL present the head byte 0 and Rx_soc SHALL be 1.
REQ-026 Otherwise in RIDLE, Rx_data SHALL be 0 and Rx_soc SHALL be 0.
REQ-027 The presented byte SHALL be consumed on each rising edge with Rx_en=0 while in RSEND, or in RIDLE with count at least 1; the next byte SHALL then be presented on the following cycle.
REQ-028 Rx_en=1 SHALL hold Rx_data/Rx_soc unchanged, including mid-cell pauses of any length.
REQ-029 Rx_en=0 in RIDLE with count 0 SHALL be ignored.
REQ-030 When the last byte of a cell is consumed, the count SHALL decrement, the slot SHALL be freed, and the read machine SHALL return to RIDLE.
REQ-031 The next cell's byte 0 (Rx_soc=1) SHALL be presented on the next cycle, with no idle cycle, if another cell is complete.
REQ-032 Simultaneous cell completion (write) and last-byte consumption (read) in one cycle SHALL leave the count unchanged.
REQ-033 The complete-cell count SHALL never exceed NCELLS or underflow.

Reset
REQ-034 rst=0 SHALL asynchronously clear pointers, the count and both state machines (IDLE, RIDLE).
REQ-035 During and after reset the outputs SHALL be Rx_data=0, Rx_soc=0, Rx_clav=0, err=0, and ld_ready=1 from the first edge after rst deasserts.
REQ-036 Reset asserted mid-cell on either side SHALL discard all buffered data; no partial cell SHALL be presented afterward.

Configuration
REQ-037 Macro UTOPIA_RX_PHY_HEC_EN defined: the byte written at cell offset 4 SHALL be replaced by the HEC computed over offsets 0..3 (CRC-8, polynomial x^8+x^2+x+1, init 0x00, result XOR 0x55), with ld_data ignored at that offset.
REQ-038 Macro UTOPIA_RX_PHY_HEC_EN undefined: offset 4 SHALL be stored as received, with no HEC logic present.

Verification
REQ-039 Load one cell of bytes 0x00..0x34 with ld_soc on byte 0 and Rx_en=1 -> Rx_clav=1 one edge after the 53rd byte; Rx_data=0x00 and Rx_soc=1 held.
REQ-040 Rx_en=0 for 53 cycles -> bytes 0x00..0x34 appear in order, Rx_soc only on 0x00, Rx_clav=0 after the last byte.
REQ-041 Load 2 cells, then offer a 3rd -> ld_ready=0; one cell read out -> ld_ready=1, no byte lost.
REQ-042 ld_soc=1 at offset 20, then 53 good bytes -> err pulses once; the cell read out equals the second cell only.
REQ-043 Rx_en=1 for 10 cycles at offset 30 -> Rx_data stable; resume gives offset 31; rst=0 mid-read -> all outputs reset, Rx_clav=0.
REQ-044 With UTOPIA_RX_PHY_HEC_EN, header bytes 0x00,0x00,0x00,0x00 -> offset 4 reads 0x55 regardless of ld_data.
